uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of one FIFO entry (matches the controller's maximum UART data width).
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter ADDR_W, default 4, pointer width equal to $clog2(DEPTH).
REQ-004 Parameter AFULL_LVL, default 12, count at or above which almost_full_o asserts; range 1..DEPTH.
REQ-005 clk_i  in  1  single clock; every register is rising-edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 clr_i  in  1  synchronous flush, active-high.
REQ-008 push_i  in  1  write request.
REQ-009 push_data_i  in  DATA_W  write data.
REQ-010 pop_i  in  1  read request; connects to the Tx pop strobe or to the host read strobe.
REQ-011 pop_data_o  out  DATA_W  head entry (first-word-fall-through).
REQ-012 empty_o  out  1  FIFO holds 0 entries.
REQ-013 full_o  out  1  FIFO holds DEPTH entries.
REQ-014 almost_full_o  out  1  count_o >= AFULL_LVL.
REQ-015 count_o  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-016 overflow_o  out  1  sticky flag: a push was rejected.
REQ-017 underflow_o  out  1  sticky flag: a pop was rejected.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_W register array with ADDR_W-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-019 Occupancy SHALL be held in a registered (ADDR_W+1)-bit counter; empty_o, full_o and almost_full_o SHALL be decoded from this counter only.
REQ-020 Push is accepted when push_i=1 and either full_o=0, or full_o=1 with pop_i=1 in the same cycle.
REQ-021 An accepted push writes push_data_i at the write pointer on the clock edge and increments the write pointer.
REQ-022 Pop is accepted when pop_i=1 and empty_o=0; an accepted pop increments the read pointer.
REQ-023 pop_data_o SHALL equal mem[rd_ptr] combinationally, so the head is valid in the same cycle empty_o falls, with 1-cycle write-to-read latency; its value is don't-care while empty_o=1.
REQ-024 Simultaneous accepted push and pop leaves count_o unchanged.
REQ-025 push_i=1 and pop_i=1 while empty: the push is accepted, the pop is rejected, and count_o becomes 1.
REQ-026 A rejected push SHALL NOT modify memory, pointers or count.
REQ-027 A rejected pop SHALL NOT modify pointers or count.
REQ-028 clr_i=1 resets the pointers and count to 0 on the next edge, overrides push_i and pop_i in that cycle, and clears overflow_o and underflow_o; memory contents are not cleared.
REQ-029 count_o SHALL never exceed DEPTH and never go below 0.

Reset
REQ-030 Assertion of rst_ni=0 SHALL immediately set the pointers and count_o to 0, empty_o=1, full_o=0, almost_full_o=0 (and 0 when AFULL_LVL>0), overflow_o=0 and underflow_o=0.
REQ-031 The memory array SHALL NOT be reset.
REQ-032 Reset asserted mid-operation discards all entries; the first push after deassertion lands at address 0.
REQ-033 Reset deassertion is assumed synchronised externally to clk_i.

Configuration
REQ-034 Macro UART_FIFO_ERR_FLAGS_EN, when defined, SHALL enable the overflow_o and underflow_o logic: each is set on a rejected push or pop respectively and held until clr_i or reset.
REQ-035 When UART_FIFO_ERR_FLAGS_EN is undefined, overflow_o and underflow_o SHALL be tied to 0 with no flag registers inferred; all other behaviour is identical.

Verification
REQ-036 Reset, then push 0xA5 -> next cycle empty_o=0, count_o=1, pop_data_o=0xA5.
REQ-037 Push 16 entries 0x00..0x0F, then push 0xFF -> full_o=1, count_o=16, and 0xFF is dropped; with the macro defined, overflow_o=1; popping all 16 returns 0x00..0x0F in order.
REQ-038 Pop while empty -> count_o stays 0; with the macro defined, underflow_o=1; then clr_i -> underflow_o=0.
REQ-039 With the FIFO full, push 0x5A and pop together -> count_o stays 16, 0x00 is popped, and 0x5A becomes the 16th entry; likewise with the FIFO empty, push and pop together -> count_o=1.
REQ-040 Push 20 and pop 20 interleaved -> pointers wrap past 15 and the data stream is returned intact; almost_full_o is 1 exactly while count_o>=12.
REQ-041 Assert rst_ni=0 asynchronously with count_o=7 -> all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous first-word-fall-through FIFO for the UART
//                controller data paths. It has a registered occupancy counter
//                and optional sticky overflow/underflow flags.
//  Config      : UART_FIFO_ERR_FLAGS_EN - define to enable the sticky
//                overflow_o / underflow_o flags. When it is undefined, both
//                outputs are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic push_acc;
    logic pop_acc;
    logic push_ok;
    logic pop_ok;

    // Flags come only from the registered count. A push into a full FIFO is
    // legal when a pop frees the head slot on the same edge.
    always_comb begin
        empty_o       = (count == '0);
        full_o        = (count == FULL_CNT);
        almost_full_o = (count >= AFULL_CNT);
        count_o       = count;
        pop_data_o    = mem[rd_ptr];
        pop_acc       = pop_i & ~empty_o;
        push_acc      = push_i & (~full_o | pop_i);
        push_ok       = push_acc & ~clr_i;
        pop_ok        = pop_acc & ~clr_i;
    end

    // Storage array is deliberately not reset; only accepted pushes write it.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Flush has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic ovf_flag;
    logic unf_flag;

    // Sticky error flags: set on a rejected request, cleared only by flush/reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else if (clr_i) begin
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            if (push_i && !push_acc) begin
                ovf_flag <= 1'b1;
            end
            if (pop_i && !pop_acc) begin
                unf_flag <= 1'b1;
            end
        end
    end

    assign overflow_o  = ovf_flag;
    assign underflow_o = unf_flag;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_fifo
//  Description : Self-checking bench for uart_fifo. It uses a queue-based
//                reference model, directed corner cases and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int AFULL_LVL = 12;
`ifdef UART_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              empty;
    logic              full;
    logic              afull;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              unf;

    uart_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .pop_data_o   (pop_data),
        .empty_o      (empty),
        .full_o       (full),
        .almost_full_o(afull),
        .count_o      (count),
        .overflow_o   (ovf),
        .underflow_o  (unf)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a plain queue plus the two sticky flags
    logic [DATA_W-1:0] q[$];
    bit                m_ovf;
    bit                m_unf;
    bit                chk_en;
    int                n_tests;
    int                n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then advance the model by the same edge
    task automatic step(input bit c, input bit pu, input logic [DATA_W-1:0] d, input bit po);
        bit pop_ok;
        bit push_ok;
        clr       = c;
        push      = pu;
        push_data = d;
        pop       = po;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok  = po && (q.size() > 0);
            push_ok = pu && ((q.size() < DEPTH) || po);
            if (pu && !push_ok && ERR_EN) m_ovf = 1'b1;
            if (po && !pop_ok && ERR_EN)  m_unf = 1'b1;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
        #1;
        clr  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Compare all DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("almost_full", 32'(afull), 32'(q.size() >= AFULL_LVL));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("underflow", 32'(unf), 32'(m_unf));
            if (q.size() > 0) chk("pop_data", 32'(pop_data), 32'(q[0]));
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        chk_en    = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single push: visible on the next cycle
        step(0, 1, 8'hA5, 0);
        chk("first_count", 32'(count), 32'd1);
        chk("first_empty", 32'(empty), 32'd0);
        chk("first_data", 32'(pop_data), 32'hA5);
        step(1, 0, 8'h00, 0);

        // Fill to full, then push once more while full
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        step(0, 1, 8'hFF, 0);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_ovf", 32'(ovf), ERR_EN ? 32'd1 : 32'd0);

        // Push and pop together while full
        chk("full_head", 32'(pop_data), 32'h00);
        step(0, 1, 8'h5A, 1);
        chk("fullpp_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", 32'(pop_data), (i < DEPTH - 1) ? 32'(i + 1) : 32'h5A);
            step(0, 0, 8'h00, 1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Pop while empty, then flush the flags
        step(0, 0, 8'h00, 1);
        chk("under_count", 32'(count), 32'd0);
        chk("under_unf", 32'(unf), ERR_EN ? 32'd1 : 32'd0);
        step(1, 0, 8'h00, 0);
        chk("clr_unf", 32'(unf), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Push and pop together while empty
        step(0, 1, 8'h3C, 1);
        chk("emptypp_count", 32'(count), 32'd1);
        chk("emptypp_data", 32'(pop_data), 32'h3C);
        step(1, 0, 8'h00, 0);

        // 20 pushes and 20 pops, interleaved, so the pointers wrap
        for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h80 + i), (i >= 13));
        for (int i = 0; i < 13; i++) step(0, 0, 8'h00, 1);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Randomized traffic in three phases: filling, balanced, draining
        for (int i = 0; i < 3000; i++) begin
            int pp;
            int pq;
            pp = (i < 1000) ? 70 : (i < 2000) ? 50 : 30;
            pq = (i < 1000) ? 30 : (i < 2000) ? 50 : 70;
            step(($urandom_range(0, 127) == 0),
                 ($urandom_range(0, 99) < pp),
                 8'($urandom),
                 ($urandom_range(0, 99) < pq));
        end

        // Asynchronous reset in mid-cycle with 7 entries held
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h40 + i), 0);
        chk("pre_rst_count", 32'(count), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_afull", 32'(afull), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_unf", 32'(unf), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 8'hC3, 0);
        chk("post_rst_data", 32'(pop_data), 32'hC3);
        chk("post_rst_count", 32'(count), 32'd1);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
